// File: rtl/if_redirect_ctrl.sv
// if_redirect_ctrl: IF-stage redirect pulse, idle gating, in-flight fetch tracking and stale-response discard.
module if_redirect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  input  logic        br_valid,
  input  logic [31:0] br_pc,
  input  logic        idle_req,
  input  logic        req_fire,
  input  logic        resp_fire,
  output logic        need_jump,
  output logic [31:0] jump_pc,
  output logic        flush_IF,
  output logic        fetch_en,
  output logic        resp_discard,
  output logic [1:0]  inflight,
  output logic        proto_err
);
  typedef enum logic {RUN, IDLE_WAIT} state_t;
  state_t      state_q, state_d;
  logic        need_jump_q, need_jump_d;
  logic [31:0] jump_pc_q, jump_pc_d;
  logic [1:0]  inflight_q, inflight_d;
  logic [1:0]  discard_q, discard_d;
  logic        proto_err_q, proto_err_d;
  logic        redir, inc, dec, err;
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end
  always_comb begin
    state_d = exc_valid ? RUN : (state_q == RUN && idle_req) ? IDLE_WAIT : state_q;
  end
  always_comb begin
    fetch_en     = (state_q == RUN) && (inflight_q != 2'd3);
    resp_discard = resp_fire && (need_jump_q || discard_q != 2'd0);
    redir        = exc_valid || (state_q == RUN && br_valid);
  end
  // Every fetch still outstanding after a redirect cycle belongs to the squashed path.
  always_comb begin
    inc         = req_fire && !resp_fire;
    dec         = resp_fire && !req_fire;
    err         = (inc && inflight_q == 2'd3) || (dec && inflight_q == 2'd0);
    inflight_d  = err ? inflight_q : inc ? inflight_q + 2'd1 : dec ? inflight_q - 2'd1 : inflight_q;
    proto_err_d = proto_err_q || err;
    need_jump_d = redir;
    jump_pc_d   = !redir ? jump_pc_q : exc_valid ? exc_pc : br_pc;
    discard_d   = need_jump_q ? inflight_d : (resp_fire && discard_q != 2'd0) ? discard_q - 2'd1 : discard_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      need_jump_q <= 1'b0;
      jump_pc_q   <= 32'd0;
      inflight_q  <= 2'd0;
      discard_q   <= 2'd0;
      proto_err_q <= 1'b0;
    end else begin
      need_jump_q <= need_jump_d;
      jump_pc_q   <= jump_pc_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      proto_err_q <= proto_err_d;
    end
  end
  assign need_jump = need_jump_q;
  assign flush_IF  = need_jump_q;
  assign jump_pc   = jump_pc_q;
  assign inflight  = inflight_q;
  assign proto_err = proto_err_q;
endmodule

// File: tb/tb_if_redirect_ctrl.sv
// tb_if_redirect_ctrl: directed scenarios plus random traffic checked against an epoch-tagged fetch queue model.
module tb_if_redirect_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        exc_valid = 1'b0, br_valid = 1'b0, idle_req = 1'b0, req_fire = 1'b0, resp_fire = 1'b0;
  logic [31:0] exc_pc = 32'd0, br_pc = 32'd0;
  logic        need_jump, flush_IF, fetch_en, resp_discard, proto_err;
  logic [31:0] jump_pc;
  logic [1:0]  inflight;
  int total = 0, bad = 0;

  if_redirect_ctrl dut (
    .clk(clk), .rst(rst), .exc_valid(exc_valid), .exc_pc(exc_pc), .br_valid(br_valid), .br_pc(br_pc),
    .idle_req(idle_req), .req_fire(req_fire), .resp_fire(resp_fire), .need_jump(need_jump), .jump_pc(jump_pc),
    .flush_IF(flush_IF), .fetch_en(fetch_en), .resp_discard(resp_discard), .inflight(inflight), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Model: each accepted fetch carries the epoch it was issued in; a response is stale if its epoch is old.
  bit          m_run = 1'b1, m_nj = 1'b0, m_err = 1'b0;
  logic [31:0] m_pc = 32'd0;
  int          m_q[$];
  int          m_ep = 0;
  bit          nj_now;
  int          sz;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 1'b1; m_nj = 1'b0; m_err = 1'b0; m_pc = 32'd0; m_q.delete();
    end else begin
      nj_now = m_nj;
      sz = m_q.size();
      if ((req_fire && !resp_fire && sz == 3) || (resp_fire && !req_fire && sz == 0)) m_err = 1'b1;
      else begin
        if (resp_fire && sz > 0) void'(m_q.pop_front());
        if (req_fire && !(resp_fire && sz == 0)) m_q.push_back(m_ep);
      end
      if (nj_now) m_ep++;
      if (exc_valid) begin m_nj = 1'b1; m_pc = exc_pc; end
      else if (m_run && br_valid) begin m_nj = 1'b1; m_pc = br_pc; end
      else m_nj = 1'b0;
      if (exc_valid) m_run = 1'b1;
      else if (idle_req) m_run = 1'b0;
    end
  end

  function automatic bit exp_discard();
    return resp_fire && (m_nj || (m_q.size() > 0 && m_q[0] != m_ep));
  endfunction

  function automatic bit exp_fetch();
    return m_run && m_q.size() != 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exc_valid = 0; br_valid = 0; idle_req = 0; req_fire = 0; resp_fire = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    total++; if (need_jump !== 1'b0) begin bad++; $display("FAIL rst_nj got %b exp 0", need_jump); end
    total++; if (flush_IF !== 1'b0) begin bad++; $display("FAIL rst_flush got %b exp 0", flush_IF); end
    total++; if (jump_pc !== 32'd0) begin bad++; $display("FAIL rst_pc got %h exp 0", jump_pc); end
    total++; if (inflight !== 2'd0) begin bad++; $display("FAIL rst_inflight got %0d exp 0", inflight); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_err got %b exp 0", proto_err); end
    rst = 0; tick();
    total++; if (fetch_en !== 1'b1) begin bad++; $display("FAIL rst_fetch_en got %b exp 1", fetch_en); end
    total++; if (resp_discard !== 1'b0) begin bad++; $display("FAIL rst_discard got %b exp 0", resp_discard); end
  endtask

  task automatic test_branch();
    do_reset();
    br_valid = 1; br_pc = 32'h1c000040; tick();
    br_valid = 0;
    total++; if (need_jump !== 1'b1 || flush_IF !== 1'b1) begin bad++; $display("FAIL br_pulse got %b%b exp 11", need_jump, flush_IF); end
    total++; if (jump_pc !== 32'h1c000040) begin bad++; $display("FAIL br_pc got %h exp 1c000040", jump_pc); end
    tick();
    total++; if (need_jump !== 1'b0 || flush_IF !== 1'b0) begin bad++; $display("FAIL br_one_cycle got %b%b exp 00", need_jump, flush_IF); end
  endtask

  task automatic test_priority();
    do_reset();
    exc_valid = 1; exc_pc = 32'h1c008000; br_valid = 1; br_pc = 32'h1c000040; tick();
    idle_inputs();
    total++; if (need_jump !== 1'b1) begin bad++; $display("FAIL prio_nj got %b exp 1", need_jump); end
    total++; if (jump_pc !== 32'h1c008000) begin bad++; $display("FAIL prio_pc got %h exp 1c008000", jump_pc); end
    tick();
    total++; if (need_jump !== 1'b0) begin bad++; $display("FAIL prio_single got %b exp 0", need_jump); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    br_valid = 1; br_pc = 32'h1c000100; tick();
    exc_valid = 1; exc_pc = 32'h1c000200; br_valid = 0;
    total++; if (need_jump !== 1'b1 || jump_pc !== 32'h1c000100) begin bad++; $display("FAIL b2b_first got %b %h exp 1 1c000100", need_jump, jump_pc); end
    tick();
    idle_inputs();
    total++; if (need_jump !== 1'b1 || jump_pc !== 32'h1c000200) begin bad++; $display("FAIL b2b_second got %b %h exp 1 1c000200", need_jump, jump_pc); end
    tick();
    total++; if (need_jump !== 1'b0) begin bad++; $display("FAIL b2b_end got %b exp 0", need_jump); end
  endtask

  task automatic test_discard();
    do_reset();
    req_fire = 1; tick(); tick(); tick();
    req_fire = 0;
    total++; if (inflight !== 2'd3) begin bad++; $display("FAIL disc_inflight got %0d exp 3", inflight); end
    total++; if (fetch_en !== 1'b0) begin bad++; $display("FAIL disc_fetch_en got %b exp 0", fetch_en); end
    br_valid = 1; br_pc = 32'h1c000040; tick();
    br_valid = 0; tick();
    for (int i = 0; i < 3; i++) begin
      resp_fire = 1; #1;
      total++; if (resp_discard !== 1'b1) begin bad++; $display("FAIL disc_stale%0d got %b exp 1", i, resp_discard); end
      tick();
    end
    resp_fire = 0; req_fire = 1; tick();
    req_fire = 0; resp_fire = 1; #1;
    total++; if (resp_discard !== 1'b0) begin bad++; $display("FAIL disc_fresh got %b exp 0", resp_discard); end
    tick();
    resp_fire = 0;
    total++; if (inflight !== 2'd0) begin bad++; $display("FAIL disc_drain got %0d exp 0", inflight); end
  endtask

  task automatic test_idle();
    do_reset();
    idle_req = 1; tick();
    idle_req = 0;
    total++; if (fetch_en !== 1'b0) begin bad++; $display("FAIL idle_fetch_en got %b exp 0", fetch_en); end
    br_valid = 1; br_pc = 32'h1c000040; tick();
    br_valid = 0;
    total++; if (need_jump !== 1'b0) begin bad++; $display("FAIL idle_br_ignored got %b exp 0", need_jump); end
    exc_valid = 1; exc_pc = 32'h1c001000; tick();
    exc_valid = 0;
    total++; if (need_jump !== 1'b1 || jump_pc !== 32'h1c001000) begin bad++; $display("FAIL idle_exc got %b %h exp 1 1c001000", need_jump, jump_pc); end
    total++; if (fetch_en !== 1'b1) begin bad++; $display("FAIL idle_resume got %b exp 1", fetch_en); end
  endtask

  task automatic test_proto();
    do_reset();
    resp_fire = 1; tick();
    resp_fire = 0;
    total++; if (inflight !== 2'd0 || proto_err !== 1'b1) begin bad++; $display("FAIL proto_under got %0d %b exp 0 1", inflight, proto_err); end
    req_fire = 1; tick(); tick(); tick(); tick();
    req_fire = 0;
    total++; if (inflight !== 2'd3 || proto_err !== 1'b1) begin bad++; $display("FAIL proto_sticky got %0d %b exp 3 1", inflight, proto_err); end
    rst = 1; tick(); rst = 0;
    total++; if (proto_err !== 1'b0 || inflight !== 2'd0) begin bad++; $display("FAIL proto_clear got %b %0d exp 0 0", proto_err, inflight); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    req_fire = 1; tick(); tick();
    req_fire = 0; br_valid = 1; br_pc = 32'h1c000040; tick();
    total++; if (need_jump !== 1'b1 || inflight !== 2'd2) begin bad++; $display("FAIL mid_setup got %b %0d exp 1 2", need_jump, inflight); end
    rst = 1; exc_valid = 1; exc_pc = 32'h1c00f000; idle_req = 1; req_fire = 1; tick();
    idle_inputs(); rst = 0;
    total++; if (need_jump !== 1'b0 || flush_IF !== 1'b0 || jump_pc !== 32'd0) begin bad++; $display("FAIL mid_jump got %b%b %h exp 00 0", need_jump, flush_IF, jump_pc); end
    total++; if (inflight !== 2'd0 || proto_err !== 1'b0 || fetch_en !== 1'b1) begin bad++; $display("FAIL mid_state got %0d %b %b exp 0 0 1", inflight, proto_err, fetch_en); end
    resp_fire = 1; #1;
    total++; if (resp_discard !== 1'b0) begin bad++; $display("FAIL mid_discard got %b exp 0", resp_discard); end
    resp_fire = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      exc_valid = ($urandom_range(0, 15) == 0);
      br_valid  = ($urandom_range(0, 5) == 0);
      idle_req  = ($urandom_range(0, 19) == 0);
      exc_pc    = $urandom; br_pc = $urandom;
      req_fire  = exp_fetch() && $urandom_range(0, 1);
      resp_fire = (m_q.size() > 0) && $urandom_range(0, 1);
      #1;
      total++; if (fetch_en !== exp_fetch()) begin bad++; $display("FAIL rnd_fetch_en[%0d] got %b exp %b", i, fetch_en, exp_fetch()); end
      total++; if (resp_discard !== exp_discard()) begin bad++; $display("FAIL rnd_discard[%0d] got %b exp %b", i, resp_discard, exp_discard()); end
      tick();
      total++; if (need_jump !== m_nj || flush_IF !== m_nj) begin bad++; $display("FAIL rnd_nj[%0d] got %b%b exp %b", i, need_jump, flush_IF, m_nj); end
      if (m_nj) begin
        total++; if (jump_pc !== m_pc) begin bad++; $display("FAIL rnd_pc[%0d] got %h exp %h", i, jump_pc, m_pc); end
      end
      total++; if (inflight !== 2'(m_q.size()) || proto_err !== m_err) begin bad++; $display("FAIL rnd_count[%0d] got %0d %b exp %0d %b", i, inflight, proto_err, m_q.size(), m_err); end
    end
    idle_inputs(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_back_to_back();
    test_discard();
    test_idle();
    test_proto();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
